// File: rtl/svo_tmds_dec_if.sv
// Per-lane TMDS receive bundle: deserialized word in, decoded symbol and alignment status out.
interface svo_tmds_dec_if;
    logic [9:0] din;
    logic [7:0] dout;
    logic [1:0] ctrl;
    logic       de;
    logic       valid;
    logic       locked;
    logic [3:0] slip;
    logic       err;

    modport master (output din, input dout, ctrl, de, valid, locked, slip, err);
    modport slave  (input din, output dout, ctrl, de, valid, locked, slip, err);
endinterface

// File: rtl/svo_tmds_dec.sv
// TMDS lane decoder: hunts for control-token word alignment (slip 0..9), then decodes
// each aligned symbol into pixel data or a control value.
module svo_tmds_dec #(
    parameter int LOCK_TOKENS = 8,
    parameter int DWELL       = 2048,
    parameter int MAX_ACTIVE  = 4095
) (
    input  logic           clk,
    input  logic           resetn,
    svo_tmds_dec_if.slave  bus
);

    localparam int TOK_W   = $clog2(LOCK_TOKENS + 1);
    localparam int DWELL_W = $clog2(DWELL + 1);
    localparam int ACT_W   = $clog2(MAX_ACTIVE + 1);

    localparam logic [TOK_W-1:0]   TOK_LAST   = TOK_W'(LOCK_TOKENS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [ACT_W-1:0]   ACT_MAX    = ACT_W'(MAX_ACTIVE);

    typedef enum logic {SEARCH, LOCKED} state_t;

    // {hit, value} for the four control tokens
    function automatic logic [2:0] ctl_lookup(input logic [9:0] s);
        logic [2:0] r;
        case (s)
            10'b1101010100: r = 3'b100;
            10'b0010101011: r = 3'b101;
            10'b0101010100: r = 3'b110;
            10'b1010101011: r = 3'b111;
            default:        r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] data_decode(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] q;
        d    = s[9] ? ~s[7:0] : s[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    logic [9:0]         r_cur_q, r_cur_d, r_prev_q, r_prev_d;
    state_t             state_q, state_d;
    logic [3:0]         slip_q, slip_d;
    logic [TOK_W-1:0]   tok_q, tok_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [ACT_W-1:0]   act_q, act_d;
    logic               slip_chg_q, slip_chg_d;
    logic [7:0]         dout_q, dout_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic               de_q, de_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic [19:0] win;
    logic [9:0]  sym;
    logic [2:0]  ctl;
    logic        is_ctl;
    logic        tok_hit;
    logic [3:0]  slip_nxt;

    always_comb begin
        win      = {r_cur_q, r_prev_q};
        sym      = 10'(win >> slip_q);
        ctl      = ctl_lookup(sym);
        is_ctl   = ctl[2];
        // the first symbol seen at a new offset straddles the old window, so it never counts
        tok_hit  = is_ctl && !slip_chg_q;
        slip_nxt = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
        r_cur_d  = bus.din;
        r_prev_d = r_cur_q;
    end

    always_comb begin
        state_d    = state_q;
        slip_d     = slip_q;
        tok_d      = tok_q;
        dwell_d    = dwell_q;
        act_d      = act_q;
        slip_chg_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            SEARCH: begin
                tok_d   = tok_hit ? ((&tok_q) ? tok_q : tok_q + 1'b1) : '0;
                dwell_d = (&dwell_q) ? dwell_q : dwell_q + 1'b1;
                if (tok_hit && tok_q == TOK_LAST) begin
                    state_d = LOCKED;
                    act_d   = '0;
                    tok_d   = '0;
                    dwell_d = '0;
                end else if (dwell_q >= DWELL_LAST) begin
                    slip_d     = slip_nxt;
                    slip_chg_d = 1'b1;
                    tok_d      = '0;
                    dwell_d    = '0;
                end
            end
            LOCKED: begin
                if (is_ctl) begin
                    act_d = '0;
                end else if (act_q >= ACT_MAX) begin
                    state_d    = SEARCH;
                    slip_d     = slip_nxt;
                    slip_chg_d = 1'b1;
                    err_d      = 1'b1;
                    tok_d      = '0;
                    dwell_d    = '0;
                    act_d      = '0;
                end else begin
                    act_d = act_q + 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        dout_d  = dout_q;
        ctrl_d  = ctrl_q;
        de_d    = 1'b0;
        valid_d = (state_q == LOCKED);
        if (is_ctl) begin
            ctrl_d = ctl[1:0];
        end else begin
            dout_d = data_decode(sym);
            de_d   = (state_q == LOCKED);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cur_q    <= '0;
            r_prev_q   <= '0;
            state_q    <= SEARCH;
            slip_q     <= '0;
            tok_q      <= '0;
            dwell_q    <= '0;
            act_q      <= '0;
            slip_chg_q <= 1'b0;
            dout_q     <= '0;
            ctrl_q     <= '0;
            de_q       <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            r_cur_q    <= r_cur_d;
            r_prev_q   <= r_prev_d;
            state_q    <= state_d;
            slip_q     <= slip_d;
            tok_q      <= tok_d;
            dwell_q    <= dwell_d;
            act_q      <= act_d;
            slip_chg_q <= slip_chg_d;
            dout_q     <= dout_d;
            ctrl_q     <= ctrl_d;
            de_q       <= de_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.ctrl   = ctrl_q;
    assign bus.de     = de_q;
    assign bus.valid  = valid_q;
    assign bus.locked = (state_q == LOCKED);
    assign bus.slip   = slip_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_svo_tmds_dec.sv
// Bench for svo_tmds_dec: a TMDS encoder model produces symbols whose decode is known,
// and a serial bit queue recreates a word-misaligned lane.
module tb_svo_tmds_dec;

    localparam int LOCK_TOKENS = 8;
    localparam int DWELL       = 64;
    localparam int MAX_ACTIVE  = 32;
    localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                       10'b0101010100, 10'b1010101011};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   bitq[$];

    svo_tmds_dec_if bus();

    svo_tmds_dec #(.LOCK_TOKENS(LOCK_TOKENS), .DWELL(DWELL), .MAX_ACTIVE(MAX_ACTIVE)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Standard transition-minimising TMDS encoding; DC-balance bit chosen by the caller.
    function automatic logic [9:0] tmds_enc(input logic [7:0] b, input logic inv);
        int ones;
        logic [8:0] qm;
        ones  = $countones(b);
        qm[0] = b[0];
        if (ones > 4 || (ones == 4 && b[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
            qm[8] = 1'b1;
        end
        return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    endfunction

    task automatic tick(input logic [9:0] w);
        bus.din = w;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_sym(input logic [9:0] s);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) bitq.push_back(s[i]);
        while (bitq.size() >= 10) begin
            for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
            tick(w);
        end
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        bus.din = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        bitq.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick(10'($urandom));
            total++;
            if ({bus.dout, bus.ctrl, bus.de, bus.valid, bus.locked, bus.slip, bus.err} !== 19'd0) begin
                bad++;
                $display("FAIL reset n=%0d got dout=%h ctrl=%b de=%b valid=%b locked=%b slip=%0d err=%b want all 0",
                         n, bus.dout, bus.ctrl, bus.de, bus.valid, bus.locked, bus.slip, bus.err);
            end
        end
    endtask

    task automatic test_aligned_lock();
        logic [9:0] w;
        do_reset();
        for (int t = 1; t <= 20; t++) begin
            w = (t == 17) ? 10'b0100000000 : (t == 18) ? 10'b1000000000 : TOK[0];
            tick(w);
            if (t == 9) begin
                total++;
                if (bus.locked !== 1'b0) begin
                    bad++;
                    $display("FAIL lock_early got locked=%b want 0", bus.locked);
                end
            end
            if (t == 10) begin
                total++;
                if (bus.locked !== 1'b1 || bus.slip !== 4'd0 || bus.ctrl !== 2'b00 || bus.de !== 1'b0 || bus.valid !== 1'b0) begin
                    bad++;
                    $display("FAIL lock_edge got locked=%b slip=%0d ctrl=%b de=%b valid=%b want 1 0 00 0 0",
                             bus.locked, bus.slip, bus.ctrl, bus.de, bus.valid);
                end
            end
            if (t == 11) begin
                total++;
                if (bus.valid !== 1'b1 || bus.de !== 1'b0) begin
                    bad++;
                    $display("FAIL valid_rise got valid=%b de=%b want 1 0", bus.valid, bus.de);
                end
            end
            if (t == 19) begin
                total++;
                if (bus.dout !== 8'h00 || bus.de !== 1'b1) begin
                    bad++;
                    $display("FAIL data00 got dout=%h de=%b want 00 1", bus.dout, bus.de);
                end
            end
            if (t == 20) begin
                total++;
                if (bus.dout !== 8'hFF || bus.de !== 1'b1 || bus.locked !== 1'b1) begin
                    bad++;
                    $display("FAIL dataFF got dout=%h de=%b locked=%b want FF 1 1", bus.dout, bus.de, bus.locked);
                end
            end
        end
    endtask

    task automatic test_token_decode();
        logic [9:0] seq [6];
        logic [1:0] exp_c [6];
        seq = '{TOK[1], TOK[2], TOK[3], TOK[0], TOK[0], TOK[0]};
        exp_c = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
        for (int t = 0; t < 6; t++) begin
            tick(seq[t]);
            if (t >= 2) begin
                total++;
                if (bus.ctrl !== exp_c[t-2] || bus.de !== 1'b0 || bus.valid !== 1'b1) begin
                    bad++;
                    $display("FAIL token t=%0d got ctrl=%b de=%b valid=%b want ctrl=%b de=0 valid=1",
                             t, bus.ctrl, bus.de, bus.valid, exp_c[t-2]);
                end
            end
        end
    endtask

    task automatic test_random_data();
        logic [9:0] sym;
        bit         kq[$];
        logic [7:0] vq[$];
        bit         k;
        logic [7:0] v;
        int         run;
        run = 0;
        for (int n = 0; n < 200; n++) begin
            if (run >= 20 || $urandom_range(0, 3) == 0) begin
                k = 1'b1; v = 8'($urandom_range(0, 3)); sym = TOK[v[1:0]]; run = 0;
            end else begin
                k = 1'b0; v = 8'($urandom); sym = tmds_enc(v, 1'($urandom)); run++;
            end
            tick(sym);
            kq.push_back(k);
            vq.push_back(v);
            if (kq.size() == 3) begin
                k = kq.pop_front();
                v = vq.pop_front();
                total++;
                if (k) begin
                    if (bus.de !== 1'b0 || bus.ctrl !== v[1:0] || bus.valid !== 1'b1) begin
                        bad++;
                        $display("FAIL rand_ctl n=%0d got de=%b ctrl=%b valid=%b want de=0 ctrl=%b valid=1",
                                 n, bus.de, bus.ctrl, bus.valid, v[1:0]);
                    end
                end else begin
                    if (bus.de !== 1'b1 || bus.dout !== v || bus.valid !== 1'b1) begin
                        bad++;
                        $display("FAIL rand_data n=%0d got de=%b dout=%h valid=%b want de=1 dout=%h valid=1",
                                 n, bus.de, bus.dout, bus.valid, v);
                    end
                end
            end
        end
    endtask

    task automatic test_lock_loss();
        int errs;
        errs = 0;
        repeat (3) tick(TOK[0]);
        for (int t = 1; t <= 40; t++) begin
            if (t <= MAX_ACTIVE + 1) tick(tmds_enc(8'($urandom), 1'($urandom)));
            else tick(TOK[0]);
            if (bus.err === 1'b1) errs++;
            if (t == 34) begin
                total++;
                if (bus.locked !== 1'b1 || bus.err !== 1'b0) begin
                    bad++;
                    $display("FAIL loss_early got locked=%b err=%b want 1 0", bus.locked, bus.err);
                end
            end
            if (t == 35) begin
                total++;
                if (bus.err !== 1'b1 || bus.locked !== 1'b0 || bus.slip !== 4'd1 || bus.valid !== 1'b1) begin
                    bad++;
                    $display("FAIL loss_edge got err=%b locked=%b slip=%0d valid=%b want 1 0 1 1",
                             bus.err, bus.locked, bus.slip, bus.valid);
                end
            end
            if (t == 36) begin
                total++;
                if (bus.err !== 1'b0 || bus.valid !== 1'b0 || bus.de !== 1'b0) begin
                    bad++;
                    $display("FAIL loss_after got err=%b valid=%b de=%b want 0 0 0", bus.err, bus.valid, bus.de);
                end
            end
        end
        total++;
        if (errs != 1) begin
            bad++;
            $display("FAIL err_pulses got %0d want 1", errs);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (12) tick(TOK[0]);
        total++;
        if (bus.locked !== 1'b1) begin
            bad++;
            $display("FAIL prelock got locked=%b want 1", bus.locked);
        end
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if ({bus.dout, bus.ctrl, bus.de, bus.valid, bus.locked, bus.slip, bus.err} !== 19'd0) begin
            bad++;
            $display("FAIL async_reset got dout=%h ctrl=%b de=%b valid=%b locked=%b slip=%0d err=%b want all 0",
                     bus.dout, bus.ctrl, bus.de, bus.valid, bus.locked, bus.slip, bus.err);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick(TOK[0]);
            if (t == 9) begin
                total++;
                if (bus.locked !== 1'b0) begin
                    bad++;
                    $display("FAIL relock_early got locked=%b want 0", bus.locked);
                end
            end
            if (t == 10) begin
                total++;
                if (bus.locked !== 1'b1) begin
                    bad++;
                    $display("FAIL relock got locked=%b want 1", bus.locked);
                end
            end
        end
    endtask

    task automatic test_misaligned();
        logic [7:0] expq[$];
        logic [7:0] gotq[$];
        logic [7:0] v;
        int early;
        int run;
        early = 0;
        run = 0;
        do_reset();
        repeat (3) bitq.push_back(1'b0);
        while (cyc < 205) begin
            send_sym(TOK[0]);
            if (cyc < 201 && bus.locked === 1'b1) early++;
            if (cyc == 63 || cyc == 64 || cyc == 128 || cyc == 192) begin
                total++;
                if (bus.slip !== ((cyc == 63) ? 4'd0 : 4'(cyc / 64))) begin
                    bad++;
                    $display("FAIL slip_step cyc=%0d got slip=%0d want %0d", cyc, bus.slip,
                             (cyc == 63) ? 0 : cyc / 64);
                end
            end
            if (cyc == 201) begin
                total++;
                if (bus.locked !== 1'b1 || bus.slip !== 4'd3) begin
                    bad++;
                    $display("FAIL mis_lock got locked=%b slip=%0d want 1 3", bus.locked, bus.slip);
                end
            end
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL mis_early_lock got %0d locked cycles before 201 want 0", early);
        end
        for (int n = 0; n < 60; n++) begin
            if (run >= 10 || $urandom_range(0, 4) == 0) begin
                send_sym(TOK[$urandom_range(0, 3)]);
                run = 0;
            end else begin
                v = 8'($urandom);
                expq.push_back(v);
                send_sym(tmds_enc(v, 1'($urandom)));
                run++;
            end
            if (bus.de === 1'b1) gotq.push_back(bus.dout);
        end
        repeat (4) begin
            send_sym(TOK[0]);
            if (bus.de === 1'b1) gotq.push_back(bus.dout);
        end
        total++;
        if (gotq.size() != expq.size() || bus.slip !== 4'd3 || bus.locked !== 1'b1) begin
            bad++;
            $display("FAIL mis_count got %0d bytes slip=%0d locked=%b want %0d bytes slip=3 locked=1",
                     gotq.size(), bus.slip, bus.locked, expq.size());
        end
        for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
            total++;
            if (gotq[i] !== expq[i]) begin
                bad++;
                $display("FAIL mis_data i=%0d got %h want %h", i, gotq[i], expq[i]);
            end
        end
    endtask

    initial begin
        bus.din = '0;
        test_reset();
        test_aligned_lock();
        test_token_decode();
        test_random_data();
        test_lock_loss();
        test_async_reset();
        test_misaligned();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/svo_tmds_dec.md
# svo_tmds_dec

Receive-side counterpart of the per-channel TMDS encoder. The block takes parallel 10-bit words from a 1:10 deserializer on one TMDS data lane and finds symbol alignment (word slip 0..9) by hunting for control tokens. Once aligned, it decodes each symbol to 8-bit pixel data or a 2-bit control value, with a data-enable flag. It runs in the pixel clock domain, one instance per lane, ahead of a future sync/timing recovery stage.

## Interface
- LOCK_TOKENS, 8: consecutive control tokens required at one slip offset to declare lock
- DWELL, 2048: cycles spent at one offset in SEARCH before advancing the slip
- MAX_ACTIVE, 4095: longest legal run of non-control symbols while LOCKED

- clk  in  1  pixel clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- din  in  10  deserialized word; din[0] is the first serial bit received
- dout  out  8  decoded pixel byte
- ctrl  out  2  decoded control value {C1,C0}
- de  out  1  1 = dout is valid pixel data; 0 = control period or not locked
- valid  out  1  1 = outputs are from an aligned stream (equals locked, delayed to match data)
- locked  out  1  alignment FSM is in LOCKED
- slip  out  4  current slip offset, 0..9
- err  out  1  one-cycle pulse when lock is lost

## Operation
- Input pipeline: r_cur <= din; r_prev <= r_cur. Window W = {r_cur, r_prev} (20 bits, r_prev in bits 9:0). Aligned symbol w = W[slip +: 10].
- Control tokens are w[9:0]: 1101010100 -> 00, 0010101011 -> 01, 0101010100 -> 10, 1010101011 -> 11. is_ctl = w matches any token.
- Data decode: d = w[9] ? ~w[7:0] : w[7:0]. q[0] = d[0]. For i = 1..7: q[i] = w[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Output register per cycle:
  - is_ctl: ctrl <= token value; de <= 0; dout holds.
  - otherwise: dout <= q; de <= locked_state; ctrl holds.
  - valid <= locked_state.
- FSM states: SEARCH, LOCKED. Counters: tok_cnt (consecutive tokens), dwell_cnt, act_cnt (consecutive non-control symbols).
- SEARCH:
  - is_ctl: tok_cnt++; otherwise tok_cnt <= 0. dwell_cnt++ every cycle.
  - tok_cnt reaches LOCK_TOKENS (the LOCK_TOKENS-th consecutive token): go to LOCKED; act_cnt <= 0.
  - dwell_cnt reaches DWELL-1 without lock: slip <= (slip==9) ? 0 : slip+1; tok_cnt and dwell_cnt cleared.
  - If lock and dwell expiry occur in the same cycle, lock wins and slip is unchanged.
- LOCKED:
  - is_ctl: act_cnt <= 0; otherwise act_cnt++.
  - act_cnt would exceed MAX_ACTIVE: go to SEARCH; slip advances by one (wrapping 9 -> 0); err pulses for one cycle; all counters cleared.
  - slip is frozen while LOCKED.
- Any slip change clears tok_cnt and dwell_cnt. Because W changes, the symbol in the cycle after a slip change is not counted as a token.
- Counter widths are sized by the parameters. Counters saturate and never wrap.

## Timing
- Reset (async assert, synchronous-release use is the caller's job):
  - all outputs 0, slip = 0, state SEARCH;
  - r_cur, r_prev and all counters 0.
- Latency at slip = 0: the word on din at edge k appears on dout/ctrl/de after edge k+2. At slip s > 0, the symbol spans the words sampled at edges k-1 and k, and is output after edge k+1.
- locked rises at the same edge as the output register holding the LOCK_TOKENS-th token. valid and de follow from the next symbol onward.
- err and the fall of locked occur at the same edge. valid/de go low one edge later.
- Reset asserted mid-operation clears lock immediately. No partial state survives.

## Test plan
- Reset: hold resetn=0 with random din -> dout=0, ctrl=0, de=0, valid=0, locked=0, slip=0, err=0.
- Aligned lock (LOCK_TOKENS=8, DWELL=64): drive 16x 1101010100, then 0100000000 and 1000000000 -> locked after the 8th token with slip=0, ctrl=00/de=0; then dout=0x00/de=1, then dout=0xFF/de=1.
- Token decode: while locked, drive 0010101011, 0101010100, 1010101011, 1101010100 -> ctrl = 01, 10, 11, 00 with de=0 each.
- Misaligned stream: the same serial bitstream delayed by 3 bits -> slip steps every 64 cycles, stops at 3, and locked=1. Decoded data then matches the aligned case.
- Lock loss (MAX_ACTIVE=32): after lock, drive 33 consecutive data symbols -> err=1 for exactly one cycle, locked=0, slip advances 0 -> 1, valid=0 on the next edge.
- Async reset mid-lock: drop resetn between clock edges while locked -> all outputs 0 immediately. After release, relock requires 8 new tokens.
